tnn_popcount_sequencer: RTL and testbench
=========================================

// Module: tnn_popcount_sequencer
// PURPOSE
//  Time-multiplexes one shared 7-input popcount unit (exact or approximate popcount07 variant) over a wide ternary neuron.
//  Per input chunk, issues x&pos_mask, then x&neg_mask; accumulates pos/neg counts; forms sum=pos-neg.
//  Applies two signed thresholds to produce the ternary neuron output.
//  Sits between the neuron input register and the popcount instance; one instance per neuron.
// PARAMETERS
//  N_IN    21                          neuron input count (>=1); chunks NCH=ceil(N_IN/7), last chunk zero-padded in MSBs
//  ACC_W   $clog2(7*NCH+1)             unsigned width of pos/neg accumulators
//  SUM_W   ACC_W+1                     signed width of sum and thresholds
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      async active-low reset
//  start      in   1      request evaluation; accepted only in IDLE or DONE
//  abort      in   1      sync abort; returns to IDLE, no done
//  x          in   N_IN   activation bits, latched on accept
//  pos_mask   in   N_IN   +1 weight mask, latched on accept
//  neg_mask   in   N_IN   -1 weight mask, latched on accept
//  thr_hi     in   SUM_W  signed upper threshold, latched on accept
//  thr_lo     in   SUM_W  signed lower threshold, latched on accept
//  pc_in      out  7      registered operand to shared popcount unit
//  pc_out     in   3      popcount result (combinational from pc_in), sampled each edge while RUN
//  busy       out  1      high in RUN and FINAL
//  done       out  1      one-cycle pulse, state DONE
//  sum        out  SUM_W  signed pos_cnt-neg_cnt of last completed evaluation
//  y          out  2      ternary result: 2'b01=+1, 2'b11=-1, 2'b00=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc_in=0, busy=0, done=0, sum=0, y=2'b00, accumulators/index=0.
//  States: IDLE -> RUN -> FINAL -> DONE -> IDLE (or -> RUN if start in DONE).
//  Accept edge (start=1 in IDLE/DONE, abort=0):
//   - latch inputs; clear pos_cnt/neg_cnt.
//   - pc_in <= (x&pos_mask)[6:0]; chunk=0; phase=POS; -> RUN.
//  RUN, each edge:
//   - add zero-extended pc_out to pos_cnt (phase POS) or neg_cnt (phase NEG).
//   - then load next operand, order: POS c0, NEG c0, POS c1, NEG c1 ... NEG c(NCH-1).
//   - after NEG of last chunk: pc_in <= 0, -> FINAL.
//  FINAL edge: sum <= pos_cnt - neg_cnt (signed, SUM_W).
//   - y <= +1 if sum>thr_hi; else -1 if sum<thr_lo; else 0 (thr_hi test has priority if thr_lo>thr_hi).
//   - -> DONE.
//  DONE: done=1 for exactly one cycle; sum/y hold until the next FINAL edge.
//  Latency: accept edge to done high = 2*NCH+1 cycles (7 for N_IN=21); back-to-back throughput one result per 2*NCH+2 cycles.
//  pc_out used as delivered; no clamping or correction.
//   - approximation error of the shared unit propagates into sum.
//   - accumulators never overflow by construction (max 7 per op).
//  Overlapping pos/neg mask bits: counted in both; no resolution in this block.
//  start while busy: ignored, no queuing.
//  abort=1 on any edge: -> IDLE, pc_in=0, done not asserted, sum/y unchanged; abort beats simultaneous start.
//  Reset mid-operation: immediate return to reset values; no done.
//  pc_in=0 whenever not in RUN (keeps shared unit quiescent).
// TESTING (N_IN=21, exact popcount bench model unless noted)
//  x=all 1, pos=21'h1FFFFF, neg=0, thr_hi=10, thr_lo=-10 -> pc_in seq 7F,00,7F,00,7F,00; done at cycle 7; sum=21, y=01.
//  x=all 1, pos=0, neg=21'h1FFFFF, thr_hi=0, thr_lo=0 -> sum=-21, y=11.
//   - with thr_hi=5, thr_lo=-21 -> y=00 (boundary: sum==thr_lo is not <).
//  Eval A (sum=21) started; start pulsed in cycles 2-4 -> ignored, single done.
//   - start held in DONE cycle with new inputs -> next done exactly 8 cycles after prior done.
//  abort at cycle 3 -> IDLE next edge, no done, pc_in=0, sum/y keep previous values.
//   - rst_n low at cycle 4 -> all outputs reset immediately.
//  N_IN=10 (NCH=2), x=10'h3FF, pos=10'h3FF -> chunk1 pc_in=7'b0000111 (zero pad); sum=10.
//   - with approximate popcount07 model plugged in: sum equals sum of model outputs.

Source files
------------

// File: rtl/tnn_popcount_sequencer_if.sv
// Bundle between a ternary neuron sequencer, its controller and the shared
// 7-input popcount unit. Widths follow from N_IN so both ends agree.
interface tnn_popcount_sequencer_if #(
  parameter int N_IN = 21
);
  localparam int NCH   = (N_IN + 6) / 7;
  localparam int ACC_W = $clog2(7 * NCH + 1);
  localparam int SUM_W = ACC_W + 1;

  logic                    start;
  logic                    abort;
  logic [N_IN-1:0]         x;
  logic [N_IN-1:0]         pos_mask;
  logic [N_IN-1:0]         neg_mask;
  logic signed [SUM_W-1:0] thr_hi;
  logic signed [SUM_W-1:0] thr_lo;
  logic [6:0]              pc_in;
  logic [2:0]              pc_out;
  logic                    busy;
  logic                    done;
  logic signed [SUM_W-1:0] sum;
  logic [1:0]              y;

  // Environment side: controller plus the shared popcount unit.
  modport master (
    output start, abort, x, pos_mask, neg_mask, thr_hi, thr_lo, pc_out,
    input  pc_in, busy, done, sum, y
  );

  // Sequencer side.
  modport slave (
    input  start, abort, x, pos_mask, neg_mask, thr_hi, thr_lo, pc_out,
    output pc_in, busy, done, sum, y
  );
endinterface

// File: rtl/tnn_popcount_sequencer.sv
// Ternary neuron evaluated by time-multiplexing one shared 7-input popcount
// unit: per 7-bit chunk the positive then negative masked activations are
// issued, counts are accumulated, and sum=pos-neg is thresholded to +1/0/-1.
module tnn_popcount_sequencer #(
  parameter int N_IN = 21
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tnn_popcount_sequencer_if.slave       nif
);
  localparam int NCH   = (N_IN + 6) / 7;
  localparam int ACC_W = $clog2(7 * NCH + 1);
  localparam int SUM_W = ACC_W + 1;
  localparam int PAD_W = 7 * NCH;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t                  state_q;
  logic [PAD_W-1:0]        xp_q, xn_q;
  logic signed [SUM_W-1:0] thr_hi_q, thr_lo_q;
  logic [ACC_W-1:0]        pos_cnt_q, neg_cnt_q;
  logic [CH_W-1:0]         chunk_q;
  logic                    neg_ph_q;
  logic [6:0]              pc_in_q;
  logic                    busy_q, done_q;
  logic signed [SUM_W-1:0] sum_q;
  logic [1:0]              y_q;

  logic [PAD_W-1:0]        xp_d, xn_d;
  logic [6:0]              pos_ch [NCH];
  logic [6:0]              neg_ch [NCH];
  logic [CH_W-1:0]         chunk_nxt;
  logic                    last_chunk;
  logic signed [SUM_W-1:0] sum_d;

  // Masked activations, zero-padded to whole chunks. Only the products are
  // latched: x, pos_mask and neg_mask are never needed separately later.
  always_comb begin
    xp_d             = '0;
    xn_d             = '0;
    xp_d[N_IN-1:0]   = nif.x & nif.pos_mask;
    xn_d[N_IN-1:0]   = nif.x & nif.neg_mask;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    assign pos_ch[c] = xp_q[7*c +: 7];
    assign neg_ch[c] = xn_q[7*c +: 7];
  end

  // Operand-walk helpers and the signed difference used on the FINAL edge.
  always_comb begin
    chunk_nxt  = chunk_q + 1'b1;
    last_chunk = (chunk_q == CH_W'(NCH - 1));
    sum_d      = $signed({1'b0, pos_cnt_q}) - $signed({1'b0, neg_cnt_q});
  end

  // Sequencer FSM with registered outputs; abort beats start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xp_q      <= '0;
      xn_q      <= '0;
      thr_hi_q  <= '0;
      thr_lo_q  <= '0;
      pos_cnt_q <= '0;
      neg_cnt_q <= '0;
      chunk_q   <= '0;
      neg_ph_q  <= 1'b0;
      pc_in_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      y_q       <= 2'b00;
    end else if (nif.abort) begin
      state_q <= IDLE;
      pc_in_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (nif.start) begin
            xp_q      <= xp_d;
            xn_q      <= xn_d;
            thr_hi_q  <= nif.thr_hi;
            thr_lo_q  <= nif.thr_lo;
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
            chunk_q   <= '0;
            neg_ph_q  <= 1'b0;
            pc_in_q   <= xp_d[6:0];
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (neg_ph_q) neg_cnt_q <= neg_cnt_q + ACC_W'(nif.pc_out);
          else          pos_cnt_q <= pos_cnt_q + ACC_W'(nif.pc_out);
          if (!neg_ph_q) begin
            neg_ph_q <= 1'b1;
            pc_in_q  <= neg_ch[chunk_q];
          end else if (last_chunk) begin
            pc_in_q  <= '0;
            state_q  <= FINAL;
          end else begin
            chunk_q  <= chunk_nxt;
            neg_ph_q <= 1'b0;
            pc_in_q  <= pos_ch[chunk_nxt];
          end
        end
        FINAL: begin
          sum_q <= sum_d;
          if (sum_d > thr_hi_q)      y_q <= 2'b01;
          else if (sum_d < thr_lo_q) y_q <= 2'b11;
          else                       y_q <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          pc_in_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign nif.pc_in = pc_in_q;
  assign nif.busy  = busy_q;
  assign nif.done  = done_q;
  assign nif.sum   = sum_q;
  assign nif.y     = y_q;
endmodule

// File: tb/tb_tnn_popcount_sequencer.sv
// Bench for tnn_popcount_sequencer: N_IN=21 and N_IN=10 instances, each fed
// by a behavioural popcount unit (exact, or approximate saturating at 6).
module tb_tnn_popcount_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  tnn_popcount_sequencer_if #(.N_IN(21)) b21 ();
  tnn_popcount_sequencer_if #(.N_IN(10)) b10 ();

  tnn_popcount_sequencer #(.N_IN(21)) dut21 (.clk(clk), .rst_n(rst_n), .nif(b21.slave));
  tnn_popcount_sequencer #(.N_IN(10)) dut10 (.clk(clk), .rst_n(rst_n), .nif(b10.slave));

  logic        sel, approx, start_v, abort_v;
  logic [20:0] x_v, p_v, n_v;
  int          hi_v, lo_v;

  function automatic logic [2:0] pc_model(input logic [6:0] v, input logic a);
    int n;
    n = $countones(v);
    if (a && n == 7) n = 6;
    return 3'(n);
  endfunction

  assign b21.start    = start_v & ~sel;
  assign b10.start    = start_v & sel;
  assign b21.abort    = abort_v;
  assign b10.abort    = abort_v;
  assign b21.x        = x_v;
  assign b10.x        = x_v[9:0];
  assign b21.pos_mask = p_v;
  assign b10.pos_mask = p_v[9:0];
  assign b21.neg_mask = n_v;
  assign b10.neg_mask = n_v[9:0];
  assign b21.thr_hi   = 6'(hi_v);
  assign b10.thr_hi   = 5'(hi_v);
  assign b21.thr_lo   = 6'(lo_v);
  assign b10.thr_lo   = 5'(lo_v);
  assign b21.pc_out   = pc_model(b21.pc_in, approx);
  assign b10.pc_out   = pc_model(b10.pc_in, approx);

  int pc_s, busy_s, done_s, sum_s, y_s;
  always_comb begin
    if (sel) begin
      pc_s = int'(b10.pc_in); busy_s = int'(b10.busy); done_s = int'(b10.done);
      sum_s = int'($signed(b10.sum)); y_s = int'(b10.y);
    end else begin
      pc_s = int'(b21.pc_in); busy_s = int'(b21.busy); done_s = int'(b21.done);
      sum_s = int'($signed(b21.sum)); y_s = int'(b21.y);
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done_s != 0) done_cnt <= done_cnt + 1;

  int npass = 0, ntot = 0;
  task automatic check(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: chunk the masked vectors, sum popcounts of each operand.
  function automatic void ref_eval(input logic [20:0] x, p, n, input int nin,
                                   input int hi, lo, input logic a,
                                   output int s, output int y);
    logic [27:0] m, xp, xn;
    int nch;
    nch = (nin + 6) / 7;
    m   = (28'd1 << nin) - 28'd1;
    xp  = 28'(x & p) & m;
    xn  = 28'(x & n) & m;
    s   = 0;
    for (int c = 0; c < nch; c++) begin
      s += int'(pc_model(xp[7*c +: 7], a));
      s -= int'(pc_model(xn[7*c +: 7], a));
    end
    y = (s > hi) ? 1 : (s < lo) ? 3 : 0;
  endfunction

  int pcs[16];
  task automatic eval(input logic [20:0] x, p, n, input int hi, lo, output int lat);
    @(posedge clk); #1;
    x_v = x; p_v = p; n_v = n; hi_v = hi; lo_v = lo; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0; lat = 0; pcs[0] = pc_s;
    while (done_s == 0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 16) pcs[lat] = pc_s;
    end
  endtask

  typedef struct {
    logic [20:0] x, p, n;
    int hi, lo, s, y;
  } vec_t;
  vec_t tv[6];
  int   exp_pc[7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, lat2, d0, rs, ry;
    tv[0] = '{21'h1FFFFF, 21'h1FFFFF, 21'h000000,  10, -10,  21, 1};
    tv[1] = '{21'h1FFFFF, 21'h000000, 21'h1FFFFF,   0,   0, -21, 3};
    tv[2] = '{21'h1FFFFF, 21'h000000, 21'h1FFFFF,   5, -21, -21, 0};
    tv[3] = '{21'h1FFFFF, 21'h00007F, 21'h003F80,   0,   0,   0, 0};
    tv[4] = '{21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF,  -1,   5,   0, 1};
    tv[5] = '{21'h000001, 21'h000001, 21'h000000,   0,   0,   1, 1};
    exp_pc = '{127, 0, 127, 0, 127, 0, 0};

    sel = 1'b0; approx = 1'b0; start_v = 1'b0; abort_v = 1'b0;
    x_v = '0; p_v = '0; n_v = '0; hi_v = 0; lo_v = 0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_in", pc_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_sum", sum_s, 0);
    check("rst_y", y_s, 0);
    rst_n = 1'b1;

    // Directed table on N_IN=21.
    for (int i = 0; i < 6; i++) begin
      eval(tv[i].x, tv[i].p, tv[i].n, tv[i].hi, tv[i].lo, lat);
      check($sformatf("tv%0d_latency", i), lat, 7);
      check($sformatf("tv%0d_sum", i), sum_s, tv[i].s);
      check($sformatf("tv%0d_y", i), y_s, tv[i].y);
      if (i == 0)
        for (int k = 0; k < 7; k++) check($sformatf("tv0_pc_in_%0d", k), pcs[k], exp_pc[k]);
      @(posedge clk); #1;
      check($sformatf("tv%0d_done_pulse", i), done_s, 0);
    end

    // Starts while busy are ignored; start held in DONE restarts back-to-back.
    @(negedge clk); d0 = done_cnt;
    @(posedge clk); #1;
    x_v = 21'h1FFFFF; p_v = 21'h1FFFFF; n_v = '0; hi_v = 10; lo_v = -10; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0; lat = 0;
    while (done_s == 0 && lat < 40) begin
      if (lat >= 1 && lat <= 3) begin
        p_v = '0; n_v = 21'h1FFFFF; hi_v = 0; lo_v = 0; start_v = 1'b1;
      end else start_v = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start_v = 1'b0;
    check("busy_start_latency", lat, 7);
    check("busy_start_sum", sum_s, 21);
    check("busy_start_y", y_s, 1);
    x_v = 21'h1FFFFF; p_v = '0; n_v = 21'h1FFFFF; hi_v = 0; lo_v = 0; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0; lat2 = 1;
    while (done_s == 0 && lat2 < 40) begin
      @(posedge clk); #1;
      lat2++;
    end
    check("b2b_done_gap", lat2, 8);
    check("b2b_sum", sum_s, -21);
    check("b2b_y", y_s, 3);
    @(negedge clk); #1;
    check("b2b_done_count", done_cnt - d0, 2);

    // Abort at cycle 3: back to IDLE, results untouched, no done.
    @(posedge clk); #1;
    x_v = 21'h1FFFFF; p_v = 21'h1FFFFF; n_v = '0; hi_v = 10; lo_v = -10; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_abort_busy", busy_s, 1);
    abort_v = 1'b1;
    @(posedge clk); #1;
    abort_v = 1'b0;
    check("abort_busy", busy_s, 0);
    check("abort_pc_in", pc_s, 0);
    check("abort_sum", sum_s, -21);
    check("abort_y", y_s, 3);
    @(negedge clk); d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);

    // Abort wins over a simultaneous start.
    start_v = 1'b1; abort_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0; abort_v = 1'b0;
    check("abort_beats_start_busy", busy_s, 0);
    check("abort_beats_start_pc_in", pc_s, 0);

    // Asynchronous reset mid-evaluation.
    @(posedge clk); #1;
    start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_pc_in", pc_s, 127);
    rst_n = 1'b0;
    #1;
    check("midrst_pc_in", pc_s, 0);
    check("midrst_busy", busy_s, 0);
    check("midrst_done", done_s, 0);
    check("midrst_sum", sum_s, 0);
    check("midrst_y", y_s, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized N_IN=21 against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [20:0] rx, rp, rn;
      int rh, rl;
      rx = 21'($urandom); rp = 21'($urandom); rn = 21'($urandom);
      rh = int'($urandom_range(40)) - 20;
      rl = int'($urandom_range(40)) - 20;
      ref_eval(rx, rp, rn, 21, rh, rl, 1'b0, rs, ry);
      eval(rx, rp, rn, rh, rl, lat);
      check($sformatf("rnd%0d_sum", i), sum_s, rs);
      check($sformatf("rnd%0d_y", i), y_s, ry);
    end

    // N_IN=10: padded last chunk, then approximate popcount.
    sel = 1'b1;
    eval(21'h3FF, 21'h3FF, 21'h0, 0, 0, lat);
    check("n10_latency", lat, 5);
    check("n10_chunk1_pc_in", pcs[2], 7);
    check("n10_sum", sum_s, 10);
    check("n10_y", y_s, 1);
    approx = 1'b1;
    ref_eval(21'h3FF, 21'h3FF, 21'h0, 10, 0, 0, 1'b1, rs, ry);
    eval(21'h3FF, 21'h3FF, 21'h0, 0, 0, lat);
    check("n10_approx_sum", sum_s, rs);
    for (int i = 0; i < 10; i++) begin
      logic [20:0] rx, rp, rn;
      int rh, rl;
      rx = 21'($urandom) & 21'h3FF; rp = 21'($urandom) & 21'h3FF; rn = 21'($urandom) & 21'h3FF;
      rh = int'($urandom_range(20)) - 10;
      rl = int'($urandom_range(20)) - 10;
      ref_eval(rx, rp, rn, 10, rh, rl, 1'b1, rs, ry);
      eval(rx, rp, rn, rh, rl, lat);
      check($sformatf("n10_rnd%0d_sum", i), sum_s, rs);
      check($sformatf("n10_rnd%0d_y", i), y_s, ry);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
